// File: rtl/ps2_cmd_pkg.sv
// Shared constants and types for the PS/2 scan-code to game-command controller:
// opcodes, set-2 scan codes, prefix FSM states and small decode helpers.
package ps2_cmd_pkg;

  localparam logic [1:0] OP_TOGGLE    = 2'd0;
  localparam logic [1:0] OP_RUN_PAUSE = 2'd1;
  localparam logic [1:0] OP_STEP      = 2'd2;
  localparam logic [1:0] OP_CLEAR     = 2'd3;

  localparam logic [7:0] SC_E0       = 8'hE0;
  localparam logic [7:0] SC_F0       = 8'hF0;
  localparam logic [7:0] SC_UP_EXT   = 8'h75;
  localparam logic [7:0] SC_DOWN_EXT = 8'h72;
  localparam logic [7:0] SC_LEFT_EXT = 8'h6B;
  localparam logic [7:0] SC_RIGHT_EXT= 8'h74;
  localparam logic [7:0] SC_W        = 8'h1D;
  localparam logic [7:0] SC_S        = 8'h1B;
  localparam logic [7:0] SC_A        = 8'h1C;
  localparam logic [7:0] SC_D        = 8'h23;
  localparam logic [7:0] SC_SPACE    = 8'h29;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_N        = 8'h31;
  localparam logic [7:0] SC_C        = 8'h21;

  typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} pfx_state_t;

  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] op;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(input logic [7:0] code);
    cmd_dec_t d;
    d = '{hit: 1'b1, op: OP_TOGGLE};
    case (code)
      SC_SPACE: d.op = OP_TOGGLE;
      SC_ENTER: d.op = OP_RUN_PAUSE;
      SC_N:     d.op = OP_STEP;
      SC_C:     d.op = OP_CLEAR;
      default:  d.hit = 1'b0;
    endcase
    return d;
  endfunction

  // Arrow keys live behind E0; WASD are plain codes. Same byte means different keys.
  function automatic dir_t decode_dir(input logic ext, input logic [7:0] code);
    dir_t d;
    d = DIR_NONE;
    if (ext) begin
      case (code)
        SC_UP_EXT:    d = DIR_UP;
        SC_DOWN_EXT:  d = DIR_DOWN;
        SC_LEFT_EXT:  d = DIR_LEFT;
        SC_RIGHT_EXT: d = DIR_RIGHT;
        default:      d = DIR_NONE;
      endcase
    end else begin
      case (code)
        SC_W:    d = DIR_UP;
        SC_S:    d = DIR_DOWN;
        SC_A:    d = DIR_LEFT;
        SC_D:    d = DIR_RIGHT;
        default: d = DIR_NONE;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO; extra pointer bit separates full from empty.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                wp, rp;
  logic [DEPTH-1:0][W-1:0]    mem;
  logic                       push_ok, pop_ok;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_ok) wp <= wp + (AW+1)'(1);
      if (pop_ok)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_key_cmd_ctrl.sv
// Resolves PS/2 E0/F0 prefixes into make/break events, moves the edit cursor
// and queues edit/run commands for the life engine.
module ps2_key_cmd_ctrl
  import ps2_cmd_pkg::*;
#(
  parameter int GRID_W         = 32,
  parameter int GRID_H         = 24,
  parameter int XW             = 5,
  parameter int YW             = 5,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_byte,
  input  logic          rx_valid,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          cmd_valid,
  output logic [1:0]    cmd_op,
  output logic [XW-1:0] cmd_x,
  output logic [YW-1:0] cmd_y,
  input  logic          cmd_ready,
  output logic          overflow
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = 2 + XW + YW;

  pfx_state_t    state, state_nxt;
  logic [CW-1:0] to_cnt;
  logic          to_hit;
  logic          mk, brk, ext;

  dir_t          dir;
  cmd_dec_t      dec;
  logic          cmd_mk, held_brk, push, pop;
  logic          held_vld;
  logic [1:0]    held_op;

  logic          full, empty;
  logic [DW-1:0] head;

  assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mk        = 1'b0;
    brk       = 1'b0;
    ext       = 1'b0;
    case (state)
      ST_IDLE: if (rx_valid) begin
        if (rx_byte == SC_E0)      state_nxt = ST_E0;
        else if (rx_byte == SC_F0) state_nxt = ST_F0;
        else                       mk = 1'b1;
      end
      ST_E0: if (rx_valid) begin
        if (rx_byte == SC_F0) state_nxt = ST_E0F0;
        else begin
          mk        = 1'b1;
          ext       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end else if (to_hit) state_nxt = ST_IDLE;
      ST_F0: if (rx_valid) begin
        brk       = 1'b1;
        state_nxt = ST_IDLE;
      end else if (to_hit) state_nxt = ST_IDLE;
      ST_E0F0: if (rx_valid) begin
        brk       = 1'b1;
        ext       = 1'b1;
        state_nxt = ST_IDLE;
      end else if (to_hit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counts silent cycles only while a prefix is pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     to_cnt <= '0;
    else if (state == ST_IDLE || rx_valid || to_hit) to_cnt <= '0;
    else                                          to_cnt <= to_cnt + CW'(1);
  end

  assign dir = mk ? decode_dir(ext, rx_byte) : DIR_NONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_x <= '0;
      cur_y <= '0;
    end else begin
      case (dir)
        DIR_UP:    cur_y <= (cur_y == '0) ? YW'(GRID_H - 1) : cur_y - YW'(1);
        DIR_DOWN:  cur_y <= (cur_y == YW'(GRID_H - 1)) ? '0 : cur_y + YW'(1);
        DIR_LEFT:  cur_x <= (cur_x == '0) ? XW'(GRID_W - 1) : cur_x - XW'(1);
        DIR_RIGHT: cur_x <= (cur_x == XW'(GRID_W - 1)) ? '0 : cur_x + XW'(1);
        default: ;
      endcase
    end
  end

  assign dec      = decode_cmd(rx_byte);
  assign cmd_mk   = mk & ~ext & dec.hit;
  assign held_brk = brk & ~ext & dec.hit & held_vld & (held_op == dec.op);
  // Typematic repeats of the held command key are swallowed here.
  assign push     = cmd_mk & ~(held_vld & (held_op == dec.op));
  assign pop      = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_vld <= 1'b0;
      held_op  <= OP_TOGGLE;
    end else if (cmd_mk) begin
      held_vld <= 1'b1;
      held_op  <= dec.op;
    end else if (held_brk) begin
      held_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      overflow <= 1'b0;
    else if (push & full & ~pop)   overflow <= 1'b1;
  end

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({dec.op, cur_x, cur_y}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign cmd_valid = ~empty;
  assign {cmd_op, cmd_x, cmd_y} = cmd_valid ? head : '0;

endmodule

// File: tb/tb_ps2_key_cmd_ctrl.sv
// Bench for ps2_key_cmd_ctrl: directed scenarios plus random byte streams,
// all compared against a byte-level behavioural model of keys, cursor and queue.
module tb_ps2_key_cmd_ctrl;

  localparam int GW = 32, GH = 24, XW = 5, YW = 5, DEPTH = 4, TO = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_valid = 1'b0;
  logic          cmd_ready = 1'b0;
  logic [XW-1:0] cur_x, cmd_x;
  logic [YW-1:0] cur_y, cmd_y;
  logic          cmd_valid, overflow;
  logic [1:0]    cmd_op;

  always #5 clk = ~clk;

  ps2_key_cmd_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .XW(XW), .YW(YW),
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .cur_x(cur_x), .cur_y(cur_y), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_ready(cmd_ready), .overflow(overflow)
  );

  int n_chk = 0, n_fail = 0;

  // Behavioural model: key-level view of the byte stream.
  int          mx, my, m_cnt;
  logic [7:0]  m_held;
  bit          m_e0, m_f0, m_ovf;
  logic [11:0] m_q[$];

  function automatic logic [23:0] obs_vec();
    return {cur_x, cur_y, cmd_valid, cmd_op, cmd_x, cmd_y, overflow};
  endfunction

  function automatic logic [23:0] exp_vec();
    logic [11:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 12'h000;
    return {XW'(mx), YW'(my), m_q.size() != 0, h, m_ovf};
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; m_cnt = 0; m_held = 8'h00;
    m_e0 = 0; m_f0 = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit ext, brk, hit;
    logic [1:0] op;
    if (!m_f0 && b == 8'hF0) begin m_f0 = 1; return; end
    if (!m_e0 && !m_f0 && b == 8'hE0) begin m_e0 = 1; return; end
    ext = m_e0; brk = m_f0; m_e0 = 0; m_f0 = 0;
    hit = 1; op = 2'd0;
    case (b)
      8'h29: op = 2'd0;
      8'h5A: op = 2'd1;
      8'h31: op = 2'd2;
      8'h21: op = 2'd3;
      default: hit = 0;
    endcase
    if (brk) begin
      if (!ext && hit && b == m_held) m_held = 8'h00;
    end else if ((ext && b == 8'h75) || (!ext && b == 8'h1D)) my = (my + GH - 1) % GH;
    else if ((ext && b == 8'h72) || (!ext && b == 8'h1B)) my = (my + 1) % GH;
    else if ((ext && b == 8'h6B) || (!ext && b == 8'h1C)) mx = (mx + GW - 1) % GW;
    else if ((ext && b == 8'h74) || (!ext && b == 8'h23)) mx = (mx + 1) % GW;
    else if (!ext && hit) begin
      if (m_held != b) begin
        if (m_q.size() < DEPTH) m_q.push_back({op, XW'(mx), YW'(my)});
        else m_ovf = 1;
      end
      m_held = b;
    end
  endtask

  // One clock: drive at negedge, advance model, return at next negedge.
  task automatic step(input logic v, input logic [7:0] b, input logic rdy);
    rx_valid = v; rx_byte = b; cmd_ready = rdy;
    if (rdy && m_q.size() != 0) void'(m_q.pop_front());
    if (v) begin
      m_cnt = 0;
      model_byte(b);
    end else if (m_e0 || m_f0) begin
      m_cnt++;
      if (m_cnt == TO) begin m_e0 = 0; m_f0 = 0; m_cnt = 0; end
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; rx_valid = 1'b0; cmd_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs_vec() !== 24'h0) begin
      n_fail++; $display("FAIL reset_state got %h exp %h", obs_vec(), 24'h0);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_move_wrap();
    logic [7:0] seq[6] = '{8'hE0, 8'h75, 8'h1C, 8'h23, 8'hE0, 8'h72};
    do_reset();
    foreach (seq[i]) begin
      step(1'b1, seq[i], 1'b0);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL move_wrap[%0d] got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        n_chk++;
        if (cur_y !== 5'd23 || cur_x !== 5'd0 || cmd_valid !== 1'b0) begin
          n_fail++; $display("FAIL ext_up_wrap got x=%0d y=%0d v=%b exp x=0 y=23 v=0", cur_x, cur_y, cmd_valid);
        end
      end
      if (i == 2) begin
        n_chk++;
        if (cur_x !== 5'd31) begin
          n_fail++; $display("FAIL left_wrap got %0d exp 31", cur_x);
        end
      end
    end
  endtask

  task automatic test_repeat_suppress();
    logic [7:0] pre[7] = '{8'h23, 8'h23, 8'h23, 8'h1B, 8'h1B, 8'h1B, 8'h1B};
    logic [7:0] seq[6] = '{8'h29, 8'h29, 8'h29, 8'hF0, 8'h29, 8'h29};
    int pops = 0;
    do_reset();
    foreach (pre[i]) step(1'b1, pre[i], 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (cmd_valid && cmd_op == 2'd0 && cmd_x == 5'd3 && cmd_y == 5'd4) pops++;
      step(i < 6, (i < 6) ? seq[i] : 8'h00, 1'b1);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL repeat[%0d] got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (pops != 2) begin
      n_fail++; $display("FAIL repeat_pops got %0d exp 2", pops);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] seq[13] = '{8'h5A, 8'hF0, 8'h5A, 8'h31, 8'hF0, 8'h31, 8'h21,
                            8'hF0, 8'h21, 8'h29, 8'hF0, 8'h29, 8'h5A};
    logic [1:0] exp_ops[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    int k = 0;
    do_reset();
    foreach (seq[i]) step(1'b1, seq[i], 1'b0);
    n_chk++;
    if (overflow !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL overflow_set got ovf=%b %h exp ovf=1 %h", overflow, obs_vec(), exp_vec());
    end
    for (int i = 0; i < 6; i++) begin
      if (cmd_valid) begin
        n_chk++;
        if (k >= 4 || cmd_op !== exp_ops[k]) begin
          n_fail++; $display("FAIL overflow_order[%0d] got %0d exp %0d", k, cmd_op, (k < 4) ? exp_ops[k] : 2'd0);
        end
        k++;
      end
      step(1'b0, 8'h00, 1'b1);
    end
    n_chk++;
    if (k != 4 || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL overflow_drain got pops=%0d v=%b exp pops=4 v=0", k, cmd_valid);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(1'b1, 8'hE0, 1'b0);
    repeat (TO + 3) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h75, 1'b0);
    n_chk++;
    if (cur_y !== 5'd0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL timeout_discard got y=%0d %h exp y=0 %h", cur_y, obs_vec(), exp_vec());
    end
    step(1'b1, 8'hE0, 1'b0);
    step(1'b1, 8'h75, 1'b0);
    n_chk++;
    if (cur_y !== 5'd23) begin
      n_fail++; $display("FAIL timeout_idle got y=%0d exp 23", cur_y);
    end
    step(1'b1, 8'hE0, 1'b0);
    repeat (TO - 5) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h75, 1'b0);
    n_chk++;
    if (cur_y !== 5'd22 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL timeout_within got y=%0d exp 22", cur_y);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] seq[10] = '{8'h29, 8'hF0, 8'h29, 8'h5A, 8'hF0, 8'h5A, 8'h31, 8'hF0, 8'h31, 8'h21};
    int pops = 0;
    do_reset();
    foreach (seq[i]) step(1'b1, seq[i], 1'b0);
    step(1'b1, 8'h29, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    n_chk++;
    if (overflow !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL full_pop got %h exp %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 6; i++) begin
      if (cmd_valid) pops++;
      step(1'b0, 8'h00, 1'b1);
    end
    n_chk++;
    if (pops != 4) begin
      n_fail++; $display("FAIL full_pop_count got %0d exp 4", pops);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq[6] = '{8'h23, 8'h29, 8'hF0, 8'h29, 8'h5A, 8'hF0};
    do_reset();
    foreach (seq[i]) step(1'b1, seq[i], 1'b0);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (cmd_valid !== 1'b0 || cur_x !== 5'd0 || cur_y !== 5'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid got v=%b x=%0d y=%0d ovf=%b exp all 0", cmd_valid, cur_x, cur_y, overflow);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'h29, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    n_chk++;
    if (cmd_valid !== 1'b1 || cmd_op !== 2'd0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_mid_next got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[16] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B,
                             8'h1C, 8'h23, 8'h29, 8'h5A, 8'h31, 8'h21, 8'hF0, 8'h00};
    logic [7:0] b;
    logic v, r;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 2) != 0);
      b = pool[$urandom_range(0, 15)];
      if (b == 8'h00) b = 8'($urandom());
      r = ($urandom_range(0, 3) == 0);
      step(v, b, r);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d] byte %h got %h exp %h", i, b, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_move_wrap();
    test_repeat_suppress();
    test_overflow();
    test_timeout();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
